prng_arbiter: RTL and testbench
===============================

Name: prng_arbiter

Overview:
- Sequences and shares one prng core among NREQ requesters; the core is an 18/25-bit LFSR pair feeding a DSP48 product.
- Loads seeds into the core, runs a warm-up of discarded steps, then round-robin grants one fresh random word per cycle.
- Each word goes to exactly one requester, and no word is ever delivered twice.
- Sits between the prng core (seed-load/enable variant) and consumers such as noise injectors and dither units.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W0, 18, width of LFSR 0 seed.
- W1, 25, width of LFSR 1 seed.
- WOUT, 32, random word width.
- WARMUP, 64, core steps discarded after every seed load (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_valid  in  1  seed offer.
- seed0  in  W0  LFSR 0 seed.
- seed1  in  W1  LFSR 1 seed.
- seed_ready  out  1  seed accepted when seed_valid&&seed_ready.
- req  in  NREQ  level request per requester.
- gnt  out  NREQ  registered one-hot grant, accompanies rnd_valid.
- rnd_valid  out  1  rnd_data valid this cycle for requester gnt.
- rnd_data  out  WOUT  random word.
- core_load  out  1  core loads core_seed0/1 at this edge.
- core_seed0  out  W0  seed to core.
- core_seed1  out  W1  seed to core.
- core_en  out  1  core advances one step at this edge.
- core_dout  in  WOUT  core output register; new value visible the cycle after core_en or core_load.
- running  out  1  state==RUN.
- words_out  out  32  count of words delivered, saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async, rst=1):
  - State UNSEEDED.
  - gnt=0, rnd_valid=0, rnd_data=0.
  - core_load=0, core_en=0, core_seed0/1=0.
  - Round-robin pointer=0, warm-up counter=0, words_out=0, running=0.
- States: UNSEEDED, LOAD, WARMUP, RUN.
- seed_ready is 1 only in UNSEEDED and RUN. A seed handshake in either state moves to LOAD next cycle.
- Zero-seed guard:
  - A seed equal to 0 is replaced by 1 for that LFSR, since all-zero locks the LFSR.
  - The guard is applied when the seed is registered at the handshake.
- LOAD (exactly 1 cycle):
  - core_load=1 with the registered seeds.
  - Warm-up counter := WARMUP.
  - Next state WARMUP.
- WARMUP:
  - core_en=1 every cycle; counter decrements.
  - Leaves for RUN on the cycle the counter reaches 1, so exactly WARMUP core steps occur.
  - Requests are ignored.
- RUN, arbitration:
  - If any req bit is set in cycle t, the winner is the first set bit at or after the pointer, searching upward and wrapping from NREQ-1 to 0.
  - At the t→t+1 edge: gnt<=onehot(winner), rnd_data<=core_dout, rnd_valid<=1, pointer<=(winner+1) mod NREQ.
  - core_en=1 combinationally in cycle t so the core produces a fresh word for t+1.
  - Latency from req to gnt/rnd_valid is 1 cycle. Sustained throughput is 1 word/cycle.
- RUN with no request: rnd_valid<=0, gnt<=0, core_en=0, pointer unchanged. Idle cycles consume no core steps.
- No backpressure: a requester must accept data in the cycle its gnt bit is high. req is level; holding it yields repeated grants in round-robin turn.
- Reseed vs request: a seed handshake in RUN takes priority over requests in the same cycle.
  - No grant is issued that cycle.
  - rnd_valid<=0 next cycle.
  - Grants resume only after the new WARMUP completes.
- Outside RUN: gnt and rnd_valid are driven 0 the cycle after leaving RUN.
- words_out increments by 1 per rnd_valid cycle, saturating.
- running is registered: 1 in the cycle after entering RUN.
- Reset mid-operation (any state) returns to UNSEEDED at once. The core is not reset by this block; it is reloaded on the next seed.

Test Plan:
- Reset, then seed0=1, seed1=1 with WARMUP=64 → core_load for 1 cycle, core_en high for exactly 64 cycles, running=1 on the following cycle, seed_ready low throughout LOAD/WARMUP.
- RUN, req=4'b1111 held for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; each rnd_data equals the core_dout from the previous cycle; no value repeats; words_out=8.
- RUN, req=4'b0101 held, pointer=0 → gnt alternates 0001,0100; req dropped to 0 → rnd_valid=0 next cycle and core_en stays 0.
- seed0=0, seed1=0 offered → core_seed0=1 and core_seed1=1 during LOAD.
- Reseed during RUN with req=4'b1111 → no gnt in the handshake cycle or in the next 1+WARMUP cycles; first grant goes to the requester at the unchanged pointer.
- rst asserted mid-WARMUP (counter=30) → all outputs 0 asynchronously, state UNSEEDED; req ignored until a new seed is accepted.

Source files
------------

// File: rtl/prng_arbiter.sv
// Sequencer and round-robin arbiter that shares one seed-load/enable PRNG core among NREQ requesters.
// Seeds the core, discards WARMUP steps, then hands out one fresh core word per grant.
module prng_arbiter #(
   parameter int NREQ   = 4,
   parameter int W0     = 18,
   parameter int W1     = 25,
   parameter int WOUT   = 32,
   parameter int WARMUP = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_valid,
   input  logic [W0-1:0]    seed0,
   input  logic [W1-1:0]    seed1,
   output logic             seed_ready,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic             rnd_valid,
   output logic [WOUT-1:0]  rnd_data,
   output logic             core_load,
   output logic [W0-1:0]    core_seed0,
   output logic [W1-1:0]    core_seed1,
   output logic             core_en,
   input  logic [WOUT-1:0]  core_dout,
   output logic             running,
   output logic [31:0]      words_out
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

   typedef enum logic [1:0] {
      S_UNSEEDED,
      S_LOAD,
      S_WARMUP,
      S_RUN
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_ptr;
   logic [CW-1:0]    r_warm_cnt;
   logic [W0-1:0]    r_seed0;
   logic [W1-1:0]    r_seed1;
   logic [NREQ-1:0]  r_gnt;
   logic             r_rnd_valid;
   logic [WOUT-1:0]  r_rnd_data;
   logic             r_running;
   logic [31:0]      r_words;

   logic             w_seed_hs;
   logic             w_any_req;
   logic             w_grant;
   logic             w_found;
   logic [PW:0]      w_idx;
   logic [PW-1:0]    w_winner;
   logic [PW-1:0]    w_ptr_next;
   logic [W0-1:0]    w_seed0_safe;
   logic [W1-1:0]    w_seed1_safe;

   assign seed_ready = (r_state == S_UNSEEDED) || (r_state == S_RUN);
   assign w_seed_hs  = seed_valid && seed_ready;
   assign w_any_req  = |req;
   // A reseed in RUN wins over any request in the same cycle.
   assign w_grant    = (r_state == S_RUN) && !w_seed_hs && w_any_req;

   assign core_load  = (r_state == S_LOAD);
   assign core_en    = (r_state == S_WARMUP) || w_grant;

   // An all-zero seed would lock its LFSR, so it is replaced by 1.
   assign w_seed0_safe = (seed0 == '0) ? W0'(1) : seed0;
   assign w_seed1_safe = (seed1 == '0) ? W1'(1) : seed1;

   // Rotating-priority search: first set request at or after r_ptr, wrapping.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_idx >= (PW+1)'(NREQ)) begin
            w_idx = w_idx - (PW+1)'(NREQ);
         end
         if (!w_found && req[w_idx[PW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[PW-1:0];
         end
      end
   end

   assign w_ptr_next = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_UNSEEDED;
         r_ptr       <= '0;
         r_warm_cnt  <= '0;
         r_seed0     <= '0;
         r_seed1     <= '0;
         r_gnt       <= '0;
         r_rnd_valid <= 1'b0;
         r_rnd_data  <= '0;
         r_running   <= 1'b0;
         r_words     <= '0;
      end else begin
         // NOTE: non-blocking throughout; these defaults are overridden only by a grant below.
         r_gnt       <= '0;
         r_rnd_valid <= 1'b0;
         case (r_state)
            S_UNSEEDED: begin
               if (w_seed_hs) begin
                  r_seed0 <= w_seed0_safe;
                  r_seed1 <= w_seed1_safe;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_warm_cnt <= CW'(WARMUP);
               r_state    <= S_WARMUP;
            end
            S_WARMUP: begin
               r_warm_cnt <= r_warm_cnt - CW'(1);
               if (r_warm_cnt == CW'(1)) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_seed_hs) begin
                  r_seed0   <= w_seed0_safe;
                  r_seed1   <= w_seed1_safe;
                  r_state   <= S_LOAD;
                  r_running <= 1'b0;
               end else if (w_any_req) begin
                  r_gnt       <= NREQ'(1) << w_winner;
                  r_rnd_valid <= 1'b1;
                  r_rnd_data  <= core_dout;
                  r_ptr       <= w_ptr_next;
                  if (r_words != 32'hFFFF_FFFF) begin
                     r_words <= r_words + 32'd1;
                  end
               end
            end
            default: begin
               r_state   <= S_UNSEEDED;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign rnd_valid  = r_rnd_valid;
   assign rnd_data   = r_rnd_data;
   assign core_seed0 = r_seed0;
   assign core_seed1 = r_seed1;
   assign running    = r_running;
   assign words_out  = r_words;

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: a stand-in core produces unique words, and a
// cycle-level reference model predicts every grant, word and counter value.
module tb_prng_arbiter;

   localparam int NREQ   = 4;
   localparam int W0     = 18;
   localparam int W1     = 25;
   localparam int WOUT   = 32;
   localparam int WARMUP = 64;

   localparam int P_UNSEEDED = 0;
   localparam int P_LOAD     = 1;
   localparam int P_WARMUP   = 2;
   localparam int P_RUN      = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             seed_valid = 1'b0;
   logic [W0-1:0]    seed0 = '0;
   logic [W1-1:0]    seed1 = '0;
   logic             seed_ready;
   logic [NREQ-1:0]  req = '0;
   logic [NREQ-1:0]  gnt;
   logic             rnd_valid;
   logic [WOUT-1:0]  rnd_data;
   logic             core_load;
   logic [W0-1:0]    core_seed0;
   logic [W1-1:0]    core_seed1;
   logic             core_en;
   logic [WOUT-1:0]  core_dout = '0;
   logic             running;
   logic [31:0]      words_out;

   int n_tests = 0;
   int n_fail  = 0;

   prng_arbiter #(
      .NREQ(NREQ), .W0(W0), .W1(W1), .WOUT(WOUT), .WARMUP(WARMUP)
   ) dut (
      .clk(clk), .rst(rst),
      .seed_valid(seed_valid), .seed0(seed0), .seed1(seed1), .seed_ready(seed_ready),
      .req(req), .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
      .core_load(core_load), .core_seed0(core_seed0), .core_seed1(core_seed1),
      .core_en(core_en), .core_dout(core_dout),
      .running(running), .words_out(words_out)
   );

   always #5 clk = ~clk;

   // Stand-in core: every step yields step_index * odd constant, so no word ever repeats.
   int unsigned core_steps = 0;
   always @(posedge clk) begin
      if (core_load || core_en) begin
         core_steps <= core_steps + 1;
         core_dout  <= (core_steps + 1) * 32'h9E37_79B1;
      end
   end

   // Reference model state
   int               m_phase;
   int               m_warm_left;
   int               m_ptr;
   logic [31:0]      m_words;
   logic [NREQ-1:0]  m_gnt;
   logic             m_valid;
   logic [WOUT-1:0]  m_data;
   logic             m_running;
   logic [W0-1:0]    m_seed0;
   logic [W1-1:0]    m_seed1;
   bit               seen [logic [WOUT-1:0]];
   int               n_en_obs;
   int               n_valid_obs;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase     = P_UNSEEDED;
      m_warm_left = 0;
      m_ptr       = 0;
      m_words     = '0;
      m_gnt       = '0;
      m_valid     = 1'b0;
      m_data      = '0;
      m_running   = 1'b0;
      m_seed0     = '0;
      m_seed1     = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"},        gnt,        0);
      check({tag, "_rnd_valid"},  rnd_valid,  0);
      check({tag, "_rnd_data"},   rnd_data,   0);
      check({tag, "_core_load"},  core_load,  0);
      check({tag, "_core_en"},    core_en,    0);
      check({tag, "_core_seed0"}, core_seed0, 0);
      check({tag, "_core_seed1"}, core_seed1, 0);
      check({tag, "_running"},    running,    0);
      check({tag, "_words_out"},  words_out,  0);
      check({tag, "_seed_ready"}, seed_ready, 1);
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance model, check registers.
   task automatic cycle(input bit sv, input logic [W0-1:0] s0, input logic [W1-1:0] s1,
                        input logic [NREQ-1:0] r);
      bit hs;
      bit exp_en;
      int win;
      seed_valid = sv;
      seed0      = s0;
      seed1      = s1;
      req        = r;
      #1;
      hs     = sv && (m_phase == P_UNSEEDED || m_phase == P_RUN);
      exp_en = (m_phase == P_WARMUP) || (m_phase == P_RUN && !hs && r != 0);
      check("seed_ready", seed_ready, (m_phase == P_UNSEEDED || m_phase == P_RUN));
      check("core_load",  core_load,  (m_phase == P_LOAD));
      check("core_en",    core_en,    exp_en);
      if (core_en) n_en_obs++;

      m_gnt   = '0;
      m_valid = 1'b0;
      case (m_phase)
         P_UNSEEDED: begin
            if (hs) begin
               m_seed0 = (s0 == 0) ? W0'(1) : s0;
               m_seed1 = (s1 == 0) ? W1'(1) : s1;
               m_phase = P_LOAD;
            end
         end
         P_LOAD: begin
            m_warm_left = WARMUP;
            m_phase     = P_WARMUP;
         end
         P_WARMUP: begin
            m_warm_left--;
            if (m_warm_left == 0) begin
               m_phase   = P_RUN;
               m_running = 1'b1;
            end
         end
         default: begin
            if (hs) begin
               m_seed0   = (s0 == 0) ? W0'(1) : s0;
               m_seed1   = (s1 == 0) ? W1'(1) : s1;
               m_phase   = P_LOAD;
               m_running = 1'b0;
            end else if (r != 0) begin
               win = -1;
               for (int k = 0; k < NREQ; k++) begin
                  int idx = (m_ptr + k) % NREQ;
                  if (win < 0 && r[idx]) win = idx;
               end
               m_gnt   = NREQ'(1) << win;
               m_valid = 1'b1;
               m_data  = core_dout;
               m_ptr   = (win + 1) % NREQ;
               if (m_words != 32'hFFFF_FFFF) m_words = m_words + 1;
            end
         end
      endcase

      @(posedge clk);
      #1;
      check("gnt",        gnt,        m_gnt);
      check("rnd_valid",  rnd_valid,  m_valid);
      check("rnd_data",   rnd_data,   m_data);
      check("running",    running,    m_running);
      check("words_out",  words_out,  m_words);
      check("core_seed0", core_seed0, m_seed0);
      check("core_seed1", core_seed1, m_seed1);
      if (rnd_valid) begin
         n_valid_obs++;
         check("unique_word", seen.exists(rnd_data), 0);
         seen[rnd_data] = 1'b1;
      end
   endtask

   initial begin
      logic [W0-1:0] rs0;
      logic [W1-1:0] rs1;
      bit            rsv;
      model_reset();

      // Reset state
      #12;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Seed 1/1, warm-up with requests ignored
      n_en_obs = 0;
      cycle(1'b1, W0'(1), W1'(1), '0);
      for (int i = 0; i < WARMUP + 10 && m_phase != P_RUN; i++) begin
         cycle(1'b0, '0, '0, 4'b1111);
      end
      check("warmup_steps", n_en_obs, WARMUP);
      check("running_after_warmup", running, 1);

      // Full request: strict rotation
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, '0, '0, 4'b1111);
         check("rr_1111", gnt, 1 << (i % 4));
      end
      check("words_after_8", words_out, 8);

      // Sparse request alternates, then idle
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, '0, '0, 4'b0101);
         check("rr_0101", gnt, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      end
      n_en_obs = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, '0, '0);
         check("idle_valid", rnd_valid, 0);
      end
      check("idle_core_steps", n_en_obs, 0);

      // Zero-seed reseed during RUN with all requests held; pointer is now 3
      cycle(1'b1, '0, '0, 4'b1111);
      check("zero_seed0", core_seed0, 1);
      check("zero_seed1", core_seed1, 1);
      n_valid_obs = 0;
      for (int i = 0; i < WARMUP + 10 && m_phase != P_RUN; i++) begin
         cycle(1'b0, '0, '0, 4'b1111);
      end
      check("no_grant_in_reseed", n_valid_obs, 0);
      cycle(1'b0, '0, '0, 4'b1111);
      check("first_grant_after_reseed", gnt, 4'b1000);

      // Randomized traffic with occasional reseeds
      for (int i = 0; i < 300; i++) begin
         rsv = ($urandom_range(0, 39) == 0);
         rs0 = ($urandom_range(0, 3) == 0) ? '0 : W0'($urandom());
         rs1 = ($urandom_range(0, 3) == 0) ? '0 : W1'($urandom());
         cycle(rsv, rs0, rs1, NREQ'($urandom()));
      end

      // Reset in the middle of warm-up
      for (int i = 0; i < WARMUP + 10 && !(m_phase == P_UNSEEDED || m_phase == P_RUN); i++) begin
         cycle(1'b0, '0, '0, '0);
      end
      cycle(1'b1, W0'($urandom()), W1'($urandom()), '0);
      for (int i = 0; i < WARMUP + 10 && !(m_phase == P_WARMUP && m_warm_left == 30); i++) begin
         cycle(1'b0, '0, '0, 4'b1111);
      end
      check("reached_count_30", m_warm_left, 30);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_valid_obs = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, '0, '0, 4'b1111);
      end
      check("req_ignored_unseeded", n_valid_obs, 0);

      // Recover: seed again and deliver a few words
      cycle(1'b1, W0'(5), W1'(9), '0);
      for (int i = 0; i < WARMUP + 10 && m_phase != P_RUN; i++) begin
         cycle(1'b0, '0, '0, '0);
      end
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, '0, '0, 4'b0110);
      end
      check("words_after_recover", words_out, 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
